// File: rtl/elevator_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elevator_scheduler : five-floor single-car SCAN scheduler (IDLE/MOVING/DOOR)|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module elevator_scheduler #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] floor_req,
  output logic [4:0] floor_pos,
  output logic [4:0] pending,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open
);

  localparam logic [7:0] MOVE_LAST = 8'(MOVE_CYCLES - 1);
  localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] move_cnt, move_cnt_n;
  logic [7:0] door_cnt, door_cnt_n;
  logic [4:0] pos_n, clr, pending_n;
  logic       dir_n;

  logic [4:0] below, above, ahead, behind;
  logic [4:0] step_pos, step_below, step_above, step_ahead;

  // For a one-hot position p, p-1 is exactly the set of floors below it.
  always_comb begin
    below      = floor_pos - 5'd1;
    above      = ~(below | floor_pos);
    ahead      = pending & (dir_up ? above : below);
    behind     = pending & (dir_up ? below : above);
    step_pos   = dir_up ? {floor_pos[3:0], 1'b0} : {1'b0, floor_pos[4:1]};
    step_below = step_pos - 5'd1;
    step_above = ~(step_below | step_pos);
    step_ahead = pending & (dir_up ? step_above : step_below);
  end

  always_comb begin
    state_n    = state;
    move_cnt_n = move_cnt;
    door_cnt_n = door_cnt;
    pos_n      = floor_pos;
    dir_n      = dir_up;
    clr        = 5'b00000;
    unique case (state)
      IDLE: begin
        if ((pending & floor_pos) != 5'b00000) begin
          state_n    = DOOR;
          door_cnt_n = 8'd0;
          clr        = floor_pos;
        end else if (ahead != 5'b00000) begin
          state_n    = MOVING;
          move_cnt_n = 8'd0;
        end else if (behind != 5'b00000) begin
          state_n    = MOVING;
          move_cnt_n = 8'd0;
          dir_n      = ~dir_up;
        end
      end
      MOVING: begin
        if (move_cnt == MOVE_LAST) begin
          pos_n      = step_pos;
          move_cnt_n = 8'd0;
          if ((pending & step_pos) != 5'b00000) begin
            state_n    = DOOR;
            door_cnt_n = 8'd0;
            clr        = step_pos;
          end else if (step_ahead == 5'b00000) begin
            state_n = IDLE;
          end
        end else begin
          move_cnt_n = move_cnt + 8'd1;
        end
      end
      DOOR: begin
        // Calls for the floor we are standing at are answered by the open door.
        clr = floor_pos;
        if (door_cnt == DOOR_LAST) begin
          state_n    = IDLE;
          door_cnt_n = 8'd0;
        end else begin
          door_cnt_n = door_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    pending_n = (pending | floor_req) & ~clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      move_cnt  <= 8'd0;
      door_cnt  <= 8'd0;
      floor_pos <= 5'b00001;
      pending   <= 5'b00000;
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_n;
      move_cnt  <= move_cnt_n;
      door_cnt  <= door_cnt_n;
      floor_pos <= pos_n;
      pending   <= pending_n;
      dir_up    <= dir_n;
      moving    <= (state_n == MOVING);
      door_open <= (state_n == DOOR);
    end
  end

endmodule
`default_nettype wire
